// File: rtl/uart_tx_port_pkg.sv
// Shared I/O definitions for the memory-mapped UART transmitter:
// bus addresses, TX FSM state encodings, status bit positions and a parity helper.
package uart_tx_port_pkg;

    localparam logic [31:0] UART_DATA_ADDR = 32'h8000_0002;
    localparam logic [31:0] UART_STAT_ADDR = 32'h8000_0003;

    // Status word bit positions
    localparam int STAT_TXE  = 0;
    localparam int STAT_BUSY = 1;
    localparam int STAT_FULL = 2;
    localparam int STAT_OVF  = 3;

    typedef enum logic [2:0] {
        UTX_IDLE   = 3'd0,
        UTX_START  = 3'd1,
        UTX_DATA   = 3'd2,
        UTX_PARITY = 3'd3,
        UTX_STOP   = 3'd4
    } utx_state_t;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_port_sync_fifo.sv
// Synchronous FIFO with occupancy count; pushes while full and pops while empty are ignored.
// Pointers wrap naturally, so DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_r == CW'(DEPTH));
    assign empty   = (count_r == CW'(0));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_r[rd_ptr_r];
    assign count   = count_r;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            wr_ptr_r <= push_ok ? wr_ptr_r + AW'(1) : wr_ptr_r;
            rd_ptr_r <= pop_ok  ? rd_ptr_r + AW'(1) : rd_ptr_r;
            case ({push_ok, pop_ok})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array write port (contents need no reset)
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped UART transmitter: bytes written to DATA_ADDR are queued and sent
// LSB first on txd (8N1). Status readable at STAT_ADDR; writing bit3 there clears ovf.
// Build option: define UART_TX_PARITY_EN to insert an even parity bit (8E1).
module uart_tx_port
    import uart_tx_port_pkg::*;
#(
    parameter int          CLK_DIV    = 868,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] DATA_ADDR  = UART_DATA_ADDR,
    parameter logic [31:0] STAT_ADDR  = UART_STAT_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bwr,
    input  logic [31:0] baddr,
    input  logic [31:0] bdi,
    output logic [31:0] bdo,
    output logic        txd,
    output logic        txe
);

    localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);

    utx_state_t      state_r, state_n;
    logic [15:0]     bcnt_r, bcnt_n;
    logic [7:0]      sh_r, sh_n;
    logic [2:0]      bi_r, bi_n;
    logic            txd_r, txd_n;
    logic            txe_r;
    logic            ovf_r;
`ifdef UART_TX_PARITY_EN
    logic            par_r, par_n;
`endif

    logic            push_req_s;
    logic            clr_req_s;
    logic            fifo_push_s;
    logic            fifo_pop_s;
    logic [7:0]      fifo_dout_s;
    logic [CW-1:0]   fifo_count_s;
    logic            full_s;
    logic            empty_s;
    logic            busy_s;
    logic [31:0]     status_s;
    logic            unused_bdi;

    assign push_req_s  = bwr && (baddr == DATA_ADDR);
    assign clr_req_s   = bwr && (baddr == STAT_ADDR) && bdi[3];
    // Full is judged on the pre-edge count, so a push colliding with a pop while full is dropped
    assign fifo_push_s = push_req_s && !full_s;
    assign busy_s      = (state_r != UTX_IDLE);
    assign unused_bdi  = ^bdi[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push_s),
        .din   (bdi[7:0]),
        .pop   (fifo_pop_s),
        .dout  (fifo_dout_s),
        .count (fifo_count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    always_comb begin
        status_s            = 32'd0;
        status_s[STAT_TXE]  = txe_r;
        status_s[STAT_BUSY] = busy_s;
        status_s[STAT_FULL] = full_s;
        status_s[STAT_OVF]  = ovf_r;
    end

    assign bdo = (baddr == STAT_ADDR) ? status_s : 32'hZZZZ_ZZZZ;
    assign txd = txd_r;
    assign txe = txe_r;

    // Sticky overflow flag; a simultaneous overflow beats a clear
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (push_req_s && full_s) begin
            ovf_r <= 1'b1;
        end else if (clr_req_s) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // TX FSM, baud counter, shifter and registered serial/empty outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= UTX_IDLE;
            bcnt_r  <= 16'd0;
            sh_r    <= 8'd0;
            bi_r    <= 3'd0;
            txd_r   <= 1'b1;
            txe_r   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_n;
            bcnt_r  <= bcnt_n;
            sh_r    <= sh_n;
            bi_r    <= bi_n;
            txd_r   <= txd_n;
            txe_r   <= empty_s && (state_r == UTX_IDLE);
`ifdef UART_TX_PARITY_EN
            par_r   <= par_n;
`endif
        end
    end

    // Next-state logic; txd_n reflects the current state so txd lags the state by one edge
    always_comb begin
        state_n    = state_r;
        bcnt_n     = bcnt_r;
        sh_n       = sh_r;
        bi_n       = bi_r;
        txd_n      = 1'b1;
        fifo_pop_s = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n      = par_r;
`endif
        case (state_r)
            UTX_IDLE: begin
                txd_n = 1'b1;
                if (fifo_count_s != CW'(0)) begin
                    fifo_pop_s = 1'b1;
                    sh_n       = fifo_dout_s;
                    bcnt_n     = BAUD_RELOAD;
                    bi_n       = 3'd0;
                    state_n    = UTX_START;
`ifdef UART_TX_PARITY_EN
                    par_n      = even_parity(fifo_dout_s);
`endif
                end else begin
                    state_n = UTX_IDLE;
                end
            end
            UTX_START: begin
                txd_n = 1'b0;
                if (bcnt_r == 16'd0) begin
                    bcnt_n  = BAUD_RELOAD;
                    state_n = UTX_DATA;
                end else begin
                    bcnt_n = bcnt_r - 16'd1;
                end
            end
            UTX_DATA: begin
                txd_n = sh_r[0];
                if (bcnt_r == 16'd0) begin
                    bcnt_n = BAUD_RELOAD;
                    sh_n   = {1'b0, sh_r[7:1]};
                    bi_n   = bi_r + 3'd1;
                    if (bi_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = UTX_PARITY;
`else
                        state_n = UTX_STOP;
`endif
                    end else begin
                        state_n = UTX_DATA;
                    end
                end else begin
                    bcnt_n = bcnt_r - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            UTX_PARITY: begin
                txd_n = par_r;
                if (bcnt_r == 16'd0) begin
                    bcnt_n  = BAUD_RELOAD;
                    state_n = UTX_STOP;
                end else begin
                    bcnt_n = bcnt_r - 16'd1;
                end
            end
`endif
            UTX_STOP: begin
                txd_n = 1'b1;
                if (bcnt_r == 16'd0) begin
                    state_n = UTX_IDLE;
                end else begin
                    bcnt_n = bcnt_r - 16'd1;
                end
            end
            default: begin
                txd_n   = 1'b1;
                state_n = UTX_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port: directed scenarios plus random bus traffic, every cycle
// compared against a frame-position model built from queue and arithmetic.
module tb_uart_tx_port;

    localparam int          CLK_DIV = 4;
    localparam int          DEPTH   = 8;
    localparam logic [31:0] DATA_A  = 32'h8000_0002;
    localparam logic [31:0] STAT_A  = 32'h8000_0003;
`ifdef UART_TX_PARITY_EN
    localparam int          NBITS   = 11;
`else
    localparam int          NBITS   = 10;
`endif
    localparam int          FRAME   = NBITS * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        bwr;
    logic [31:0] baddr;
    logic [31:0] bdi;
    wire  [31:0] bdo;
    logic        txd;
    logic        txe;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [7:0] q[$];
    logic       m_busy;
    int         m_pos;
    logic [7:0] m_byte;
    logic       m_ovf;
    logic       m_txd;
    logic       m_txe;

    uart_tx_port #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (DEPTH),
        .DATA_ADDR  (DATA_A),
        .STAT_ADDR  (STAT_A)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bwr   (bwr),
        .baddr (baddr),
        .bdi   (bdi),
        .bdo   (bdo),
        .txd   (txd),
        .txe   (txe)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line level implied by the frame position: start, 8 data bits, optional parity, stop
    function automatic logic frame_bit();
        int k;
        if (!m_busy) return 1'b1;
        k = m_pos / CLK_DIV;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[k-1];
        if (NBITS == 11 && k == 9) return ^m_byte;
        return 1'b1;
    endfunction

    task automatic model_reset();
        q.delete();
        m_busy = 1'b0;
        m_pos  = 0;
        m_byte = 8'd0;
        m_ovf  = 1'b0;
        m_txd  = 1'b1;
        m_txe  = 1'b1;
    endtask

    // One bus cycle: drive, check combinational status, clock, update model, check outputs
    task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        logic nxt_txd, nxt_txe, do_pop;
        int   pre;
        rst = r; bwr = w; baddr = a; bdi = d;
        #1;
        if (a == STAT_A)
            chk_eq("status", bdo, {28'd0, m_ovf, (q.size() == DEPTH), m_busy, m_txe});
        else
            chk_eq("bdo_z", bdo, 32'hZZZZ_ZZZZ);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            nxt_txd = frame_bit();
            nxt_txe = (q.size() == 0) && !m_busy;
            pre     = q.size();
            do_pop  = !m_busy && (pre != 0);
            if (m_busy) begin
                m_pos++;
                if (m_pos == FRAME) m_busy = 1'b0;
            end
            if (do_pop) begin
                m_byte = q.pop_front();
                m_busy = 1'b1;
                m_pos  = 0;
            end
            if (w && a == DATA_A && pre < DEPTH) q.push_back(d[7:0]);
            if (w && a == DATA_A && pre == DEPTH) m_ovf = 1'b1;
            else if (w && a == STAT_A && d[3]) m_ovf = 1'b0;
            m_txd = nxt_txd;
            m_txe = nxt_txe;
        end
        @(negedge clk);
        chk_eq("txd", {31'd0, txd}, {31'd0, m_txd});
        chk_eq("txe", {31'd0, txe}, {31'd0, m_txe});
    endtask

    initial begin
        logic        r, w;
        int          sel;
        logic [31:0] a;
        rst = 1'b1; bwr = 1'b0; baddr = 32'd0; bdi = 32'd0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        chk_eq("reset_txd", {31'd0, txd}, 32'd1);
        chk_eq("reset_txe", {31'd0, txe}, 32'd1);

        // idle status and unmapped address
        step(1'b0, 1'b0, STAT_A, 32'd0);
        step(1'b0, 1'b0, 32'h8000_0004, 32'd0);

        // single byte 0x55
        step(1'b0, 1'b1, DATA_A, 32'h55);
        repeat (50) step(1'b0, 1'b0, STAT_A, 32'd0);

        // burst past capacity to force an overflow, then drain
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, DATA_A, $urandom);
        step(1'b0, 1'b0, STAT_A, 32'd0);
        repeat (12 * (FRAME + 1) + 10) step(1'b0, 1'b0, STAT_A, 32'd0);

        // clear ovf
        step(1'b0, 1'b1, STAT_A, 32'h8);
        step(1'b0, 1'b0, STAT_A, 32'd0);

        // reset mid-frame with bytes still queued
        step(1'b0, 1'b1, DATA_A, 32'hA5);
        step(1'b0, 1'b1, DATA_A, 32'h3C);
        step(1'b0, 1'b1, DATA_A, 32'hC3);
        repeat (2 + 4 * CLK_DIV) step(1'b0, 1'b0, STAT_A, 32'd0);
        step(1'b1, 1'b0, STAT_A, 32'd0);
        repeat (60) step(1'b0, 1'b0, STAT_A, 32'd0);

        // random traffic
`ifdef UART_TX_PARITY_EN
        step(1'b0, 1'b1, DATA_A, 32'h07);
        step(1'b0, 1'b1, DATA_A, 32'h03);
        repeat (2 * (FRAME + 1) + 4) step(1'b0, 1'b0, STAT_A, 32'd0);
`endif
        repeat (3000) begin
            r   = ($urandom_range(0, 499) == 0);
            w   = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 4)      a = DATA_A;
            else if (sel < 7) a = STAT_A;
            else              a = 32'h8000_0000 | 32'($urandom_range(4, 15));
            step(r, w, a, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
